// File: rtl/fib_seq_checker_pkg.sv
// Shared definitions for the Fibonacci stream checker.
//   SEQ_LEN  : period of the checked sequence
//   FIB_LAST : last term of a period (index SEQ_LEN-1)
//   state_e  : checker state (HUNT for the leading 0, TRACK to follow the stream)
//   fib_term : constant term table T[0..9]
package fib_seq_checker_pkg;

  localparam int SEQ_LEN  = 10;
  localparam int FIB_LAST = 34;
  localparam int IDX_W    = 4;
  localparam int TERM_W   = 6;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  function automatic logic [TERM_W-1:0] fib_term(input logic [IDX_W-1:0] idx);
    logic [TERM_W-1:0] t;
    case (idx)
      4'd0:    t = 6'd0;
      4'd1:    t = 6'd1;
      4'd2:    t = 6'd1;
      4'd3:    t = 6'd2;
      4'd4:    t = 6'd3;
      4'd5:    t = 6'd5;
      4'd6:    t = 6'd8;
      4'd7:    t = 6'd13;
      4'd8:    t = 6'd21;
      4'd9:    t = TERM_W'(FIB_LAST);
      default: t = 6'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fib_seq_checker_if.sv
// Sample/status bundle between a stream source and the checker.
//   in_valid, in_data          : sample strobe and term (source -> checker)
//   locked, error, wrap        : status flags / pulses (checker -> source)
//   exp_idx                    : index of the next expected term
//   match_count, err_count     : saturating event counters
// master = stream source / observer, slave = checker.
interface fib_seq_checker_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             locked;
  logic             error;
  logic             wrap;
  logic [3:0]       exp_idx;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_data,
    input  locked, error, wrap, exp_idx, match_count, err_count
  );

  modport slave (
    input  in_valid, in_data,
    output locked, error, wrap, exp_idx, match_count, err_count
  );
endinterface

// File: rtl/fib_seq_checker_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
//   clock : posedge clock
//   i_clr : synchronous clear, wins over i_inc
//   i_inc : count one event
//   o_cnt : current count
module fib_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fib_seq_checker.sv
// Receiver-side checker for the cyclic Fibonacci stream 0,1,1,2,...,34,0,...
// Hunts for a 0, then follows the sequence, pulsing error on deviations and
// wrap on each matched 34. All outputs are registered (1-cycle latency).
//   clock : posedge clock
//   reset : synchronous active-high clear of all state
//   bus   : slave side of fib_seq_checker_if (samples in, status out)
module fib_seq_checker
  import fib_seq_checker_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  fib_seq_checker_if.slave   bus
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_LEN);
  localparam logic [3:0] LAST_I = 4'(SEQ_LEN - 1);

  state_e     r_state, w_nxt_state;
  logic [3:0] r_idx,   w_nxt_idx;
  logic [3:0] r_run,   w_nxt_run;
  logic       r_locked, w_nxt_locked;
  logic       r_error,  w_nxt_error;
  logic       r_wrap,   w_nxt_wrap;
  logic       w_match_inc, w_err_inc;

  logic [WIDTH-1:0] w_term;
  logic             w_zero;
  logic             w_hit;

  assign w_term = WIDTH'(fib_term(r_idx));
  assign w_zero = (bus.in_data == '0);
  assign w_hit  = (bus.in_data == w_term);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= HUNT;
      r_idx    <= '0;
      r_run    <= '0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_idx    <= w_nxt_idx;
      r_run    <= w_nxt_run;
      r_locked <= w_nxt_locked;
      r_error  <= w_nxt_error;
      r_wrap   <= w_nxt_wrap;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_run   = r_run;
    w_nxt_error = 1'b0;
    w_nxt_wrap  = 1'b0;
    w_match_inc = 1'b0;
    w_err_inc   = 1'b0;

    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          // Only a 0 starts tracking; anything else is silently dropped.
          if (w_zero) begin
            w_nxt_state = TRACK;
            w_nxt_idx   = 4'd1;
            w_nxt_run   = 4'd1;
            w_match_inc = 1'b1;
          end
        end
        TRACK: begin
          if (w_hit) begin
            w_nxt_idx   = (r_idx == LAST_I) ? 4'd0 : r_idx + 4'd1;
            w_nxt_run   = (r_run >= LOCK_V) ? LOCK_V : r_run + 4'd1;
            w_nxt_wrap  = (r_idx == LAST_I);
            w_match_inc = 1'b1;
          end else begin
            w_nxt_error = 1'b1;
            w_err_inc   = 1'b1;
            if (w_zero) begin
              // Unexpected 0 is both an error and the start of a new period.
              w_nxt_idx   = 4'd1;
              w_nxt_run   = 4'd1;
              w_match_inc = 1'b1;
            end else begin
              w_nxt_state = HUNT;
              w_nxt_idx   = 4'd0;
              w_nxt_run   = 4'd0;
            end
          end
        end
        default: begin
          w_nxt_state = HUNT;
          w_nxt_idx   = 4'd0;
          w_nxt_run   = 4'd0;
        end
      endcase
    end

    w_nxt_locked = (w_nxt_run >= LOCK_V);
  end

  fib_sat_counter #(.W(CNT_W)) u_match_cnt (
    .clock (clock),
    .i_clr (reset),
    .i_inc (w_match_inc),
    .o_cnt (bus.match_count)
  );

  fib_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clock (clock),
    .i_clr (reset),
    .i_inc (w_err_inc),
    .o_cnt (bus.err_count)
  );

  assign bus.locked  = r_locked;
  assign bus.error   = r_error;
  assign bus.wrap    = r_wrap;
  assign bus.exp_idx = r_idx;

endmodule
